hs_npu_pe: RTL and testbench

HS_NPU_PE -- requirements
Module: hs_npu_pe

---
 rtl/hs_npu_pe.sv | 140 ++++++++++++++
 tb/tb_hs_npu_pe.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_pe.sv
// Systolic-array processing element: a signed multiply-accumulate with a double-buffered weight,
// weight-stationary pass-sum and output-stationary accumulate modes, and optional saturation.
module hs_npu_pe #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_in,
  input  logic                     a_valid_in,
  input  logic signed [DATA_W-1:0] a_in,
  output logic                     a_valid_out,
  output logic signed [DATA_W-1:0] a_out,
  input  logic                     w_load_in,
  input  logic signed [DATA_W-1:0] w_in,
  output logic                     w_load_out,
  output logic signed [DATA_W-1:0] w_out,
  input  logic                     w_swap_in,
  output logic                     w_swap_out,
  input  logic signed [ACC_W-1:0]  sum_in,
  input  logic                     acc_clr_in,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  input  logic                     ovf_clr_in,
  output logic                     ovf
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("hs_npu_pe: ACC_W must be at least 2*DATA_W");
  end

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     r_a_valid_out;
  logic signed [DATA_W-1:0] r_a_out;
  logic signed [DATA_W-1:0] r_shadow_w;
  logic signed [DATA_W-1:0] r_active_w;
  logic                     r_w_load_out;
  logic                     r_w_swap_out;
  logic signed [ACC_W-1:0]  r_result;
  logic                     r_result_valid;
  logic                     r_ovf;

  logic signed [2*DATA_W-1:0] w_a_ext;
  logic signed [2*DATA_W-1:0] w_w_ext;
  logic signed [2*DATA_W-1:0] w_product;
  logic signed [ACC_W:0]      w_prod_ext;
  logic signed [ACC_W-1:0]    w_base;
  logic signed [ACC_W:0]      w_base_ext;
  logic signed [ACC_W:0]      w_sum;
  logic                       w_oor;
  logic signed [ACC_W-1:0]    w_fix;

  // Product always uses the weight currently active; a same-cycle swap only affects later MACs.
  assign w_a_ext    = {{DATA_W{a_in[DATA_W-1]}}, a_in};
  assign w_w_ext    = {{DATA_W{r_active_w[DATA_W-1]}}, r_active_w};
  assign w_product  = w_a_ext * w_w_ext;
  assign w_prod_ext = {{(ACC_W+1-2*DATA_W){w_product[2*DATA_W-1]}}, w_product};

  always_comb begin
    w_base = '0;
    if (!mode_in)
      w_base = sum_in;
    else if (!acc_clr_in)
      w_base = r_result;
  end

  assign w_base_ext = {w_base[ACC_W-1], w_base};
  assign w_sum      = w_prod_ext + w_base_ext;
  // The extra top bit disagrees with the ACC_W sign bit exactly when the sum leaves ACC_W range.
  assign w_oor      = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_fix = w_sum[ACC_W-1:0];
    if (w_oor && SATURATE)
      w_fix = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid_out <= 1'b0;
      r_a_out       <= '0;
    end else begin
      r_a_valid_out <= a_valid_in;
      if (a_valid_in)
        r_a_out <= a_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_w   <= '0;
      r_active_w   <= '0;
      r_w_load_out <= 1'b0;
      r_w_swap_out <= 1'b0;
    end else begin
      r_w_load_out <= w_load_in;
      r_w_swap_out <= w_swap_in;
      if (w_load_in)
        r_shadow_w <= w_in;
      if (w_swap_in)
        r_active_w <= r_shadow_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= a_valid_in;
      if (a_valid_in)
        r_result <= w_fix;
      else if (mode_in && acc_clr_in)
        r_result <= '0;
    end
  end

  // Setting wins over a simultaneous clear so no overflow event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (a_valid_in && w_oor)
      r_ovf <= 1'b1;
    else if (ovf_clr_in)
      r_ovf <= 1'b0;
  end

  assign a_valid_out  = r_a_valid_out;
  assign a_out        = r_a_out;
  assign w_load_out   = r_w_load_out;
  assign w_out        = r_shadow_w;
  assign w_swap_out   = r_w_swap_out;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign ovf          = r_ovf;

endmodule

// File: tb/tb_hs_npu_pe.sv
// Bench for hs_npu_pe: a saturating and a wrapping instance share stimulus and are
// compared against an arithmetic reference model plus directed expected values.
module tb_hs_npu_pe;

  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

  logic clk;
  logic rst_n;
  logic mode_in, a_valid_in, w_load_in, w_swap_in, acc_clr_in, ovf_clr_in;
  logic signed [15:0] a_in, w_in;
  logic signed [31:0] sum_in;

  logic a_valid_out, w_load_out, w_swap_out, result_valid, ovf;
  logic signed [15:0] a_out, w_out;
  logic signed [31:0] result;

  logic a_valid_out_w, w_load_out_w, w_swap_out_w, result_valid_w, ovf_w;
  logic signed [15:0] a_out_w, w_out_w;
  logic signed [31:0] result_w;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic signed [15:0] m_shadow, m_active, m_a_out;
  bit     m_a_valid, m_w_load, m_w_swap, m_rv;
  longint m_res_s, m_res_w;
  bit     m_ovf_s, m_ovf_w;

  hs_npu_pe #(.DATA_W(16), .ACC_W(32), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in),
    .a_valid_in(a_valid_in), .a_in(a_in), .a_valid_out(a_valid_out), .a_out(a_out),
    .w_load_in(w_load_in), .w_in(w_in), .w_load_out(w_load_out), .w_out(w_out),
    .w_swap_in(w_swap_in), .w_swap_out(w_swap_out), .sum_in(sum_in), .acc_clr_in(acc_clr_in),
    .result(result), .result_valid(result_valid), .ovf_clr_in(ovf_clr_in), .ovf(ovf)
  );

  hs_npu_pe #(.DATA_W(16), .ACC_W(32), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in),
    .a_valid_in(a_valid_in), .a_in(a_in), .a_valid_out(a_valid_out_w), .a_out(a_out_w),
    .w_load_in(w_load_in), .w_in(w_in), .w_load_out(w_load_out_w), .w_out(w_out_w),
    .w_swap_in(w_swap_in), .w_swap_out(w_swap_out_w), .sum_in(sum_in), .acc_clr_in(acc_clr_in),
    .result(result_w), .result_valid(result_valid_w), .ovf_clr_in(ovf_clr_in), .ovf(ovf_w)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint fix_sat(input longint s);
    if (s > ACC_MAX) return ACC_MAX;
    if (s < ACC_MIN) return ACC_MIN;
    return s;
  endfunction

  function automatic longint fix_wrap(input longint s);
    longint t;
    t = s & 64'h0000_0000_FFFF_FFFF;
    if (t > ACC_MAX) t = t - 64'sd4294967296;
    return t;
  endfunction

  function automatic bit out_of_range(input longint s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_a_out = 0;
    m_a_valid = 0; m_w_load = 0; m_w_swap = 0; m_rv = 0;
    m_res_s = 0; m_res_w = 0; m_ovf_s = 0; m_ovf_w = 0;
  endtask

  // One rising edge of the reference model, from the inputs presently applied.
  task automatic model_step();
    longint prod, s_s, s_w;
    prod = longint'(a_in) * longint'(m_active);
    if (mode_in) begin
      s_s = prod + (acc_clr_in ? 64'sd0 : m_res_s);
      s_w = prod + (acc_clr_in ? 64'sd0 : m_res_w);
    end else begin
      s_s = prod + longint'(sum_in);
      s_w = s_s;
    end
    if (a_valid_in) begin
      m_res_s = fix_sat(s_s);
      m_res_w = fix_wrap(s_w);
      m_rv = 1;
    end else begin
      if (mode_in && acc_clr_in) begin
        m_res_s = 0;
        m_res_w = 0;
      end
      m_rv = 0;
    end
    if (a_valid_in && out_of_range(s_s)) m_ovf_s = 1; else if (ovf_clr_in) m_ovf_s = 0;
    if (a_valid_in && out_of_range(s_w)) m_ovf_w = 1; else if (ovf_clr_in) m_ovf_w = 0;
    if (w_swap_in) m_active = m_shadow;
    if (w_load_in) m_shadow = w_in;
    m_w_load = w_load_in;
    m_w_swap = w_swap_in;
    m_a_valid = a_valid_in;
    if (a_valid_in) m_a_out = a_in;
  endtask

  // Driver tasks
  task automatic drive(input bit md, input bit av, input int a, input bit wl, input int w,
                       input bit ws, input longint sum, input bit clr, input bit oc);
    mode_in = md; a_valid_in = av; a_in = 16'(a);
    w_load_in = wl; w_in = 16'(w); w_swap_in = ws;
    sum_in = 32'(sum); acc_clr_in = clr; ovf_clr_in = oc;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'sd0 || result_valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_result got=%0d/%0b/%0b exp=0/0/0", result, result_valid, ovf);
    end
    checks++;
    if ({a_valid_out, w_load_out, w_swap_out} !== 3'b000 || a_out !== 16'sd0 || w_out !== 16'sd0) begin
      failures++;
      $display("FAIL reset_paths got=%b a=%0d w=%0d exp=000 a=0 w=0",
               {a_valid_out, w_load_out, w_swap_out}, a_out, w_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ws_basic();
    drive(0, 0, 0, 1, 3, 0, 0, 0, 0); step();
    checks++;
    if (w_out !== 16'sd3 || w_load_out !== 1'b1) begin
      failures++; $display("FAIL ws_load got=%0d/%0b exp=3/1", w_out, w_load_out);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    checks++;
    if (w_swap_out !== 1'b1 || w_load_out !== 1'b0) begin
      failures++; $display("FAIL ws_swap got=%0b/%0b exp=1/0", w_swap_out, w_load_out);
    end
    drive(0, 1, 5, 0, 0, 0, 100, 0, 0); step();
    checks++;
    if (result !== 32'sd115 || result_valid !== 1'b1) begin
      failures++; $display("FAIL ws_mac got=%0d/%0b exp=115/1", result, result_valid);
    end
    checks++;
    if (a_out !== 16'sd5 || a_valid_out !== 1'b1) begin
      failures++; $display("FAIL ws_fwd got=%0d/%0b exp=5/1", a_out, a_valid_out);
    end
    drive(0, 0, 9, 0, 0, 0, 0, 0, 0); step();
    checks++;
    if (result !== 32'sd115 || result_valid !== 1'b0 || a_out !== 16'sd5 || a_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL ws_hold got=%0d/%0b a=%0d/%0b exp=115/0 a=5/0", result, result_valid, a_out, a_valid_out);
    end
  endtask

  task automatic test_double_buffer();
    int exp_r[4] = '{12, 12, 12, -8};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4, (i == 0), -2, (i == 2), 0, 0, 0); step();
      checks++;
      if (result !== 32'(exp_r[i])) begin
        failures++; $display("FAIL dbuf_stream%0d got=%0d exp=%0d", i, result, exp_r[i]);
      end
    end
    drive(0, 0, 0, 1, 9, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 7, 1, 0, 0, 0); step();
    checks++;
    if (w_out !== 16'sd7 || w_swap_out !== 1'b1) begin
      failures++; $display("FAIL dbuf_swapload got=%0d/%0b exp=7/1", w_out, w_swap_out);
    end
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    checks++;
    if (result !== 32'sd9) begin
      failures++; $display("FAIL dbuf_old_shadow got=%0d exp=9", result);
    end
  endtask

  task automatic test_os_accum();
    int av[4]    = '{1, 1, 1, 0};
    int aval[4]  = '{1, 2, 3, 0};
    int clr[4]   = '{1, 0, 0, 1};
    int exp_r[4] = '{2, 6, 12, 0};
    drive(0, 0, 0, 1, 2, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, av[i][0], aval[i], 0, 0, 0, 0, clr[i][0], 0); step();
      checks++;
      if (result !== 32'(exp_r[i]) || result_valid !== av[i][0]) begin
        failures++;
        $display("FAIL os_accum%0d got=%0d/%0b exp=%0d/%0b", i, result, result_valid, exp_r[i], av[i][0]);
      end
    end
  endtask

  task automatic test_saturation();
    longint exp_s[3] = '{64'sd1073676289, 64'sd2147352578, 64'sd2147483647};
    longint exp_w[3] = '{64'sd1073676289, 64'sd2147352578, -64'sd1073938429};
    drive(0, 0, 0, 1, 32767, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32767, 0, 0, 0, 0, (i == 0), 0); step();
      checks++;
      if (longint'(result) !== exp_s[i] || ovf !== (i == 2)) begin
        failures++; $display("FAIL sat%0d got=%0d ovf=%0b exp=%0d ovf=%0b", i, result, ovf, exp_s[i], (i == 2));
      end
      checks++;
      if (longint'(result_w) !== exp_w[i] || ovf_w !== (i == 2)) begin
        failures++; $display("FAIL wrap%0d got=%0d ovf=%0b exp=%0d ovf=%0b", i, result_w, ovf_w, exp_w[i], (i == 2));
      end
    end
  endtask

  task automatic test_neg_clamp();
    drive(0, 0, 0, 1, -32768, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL neg_preclear got=%0b exp=0", ovf);
    end
    drive(0, 1, 32767, 0, 0, 0, ACC_MIN, 0, 0); step();
    checks++;
    if (longint'(result) !== ACC_MIN || ovf !== 1'b1) begin
      failures++; $display("FAIL neg_clamp got=%0d ovf=%0b exp=%0d ovf=1", result, ovf, ACC_MIN);
    end
    checks++;
    if (longint'(result_w) !== m_res_w || longint'(result_w) !== 64'sd1073774592) begin
      failures++; $display("FAIL neg_wrap got=%0d exp=1073774592", result_w);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    checks++;
    if (ovf !== 1'b0 || ovf_w !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%0b/%0b exp=0/0", ovf, ovf_w);
    end
    drive(0, 1, 32767, 0, 0, 0, ACC_MIN, 0, 1); step();
    checks++;
    if (ovf !== 1'b1 || ovf_w !== 1'b1) begin
      failures++; $display("FAIL ovf_set_wins got=%0b/%0b exp=1/1", ovf, ovf_w);
    end
  endtask

  task automatic test_mode_switch();
    drive(0, 0, 0, 1, 10, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(1, 1, 3, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 555, 0, 0); step();
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0); step();
    checks++;
    if (result !== 32'sd50) begin
      failures++; $display("FAIL mode_keep_acc got=%0d exp=50", result);
    end
    drive(0, 1, 1, 0, 0, 0, 7, 0, 0); step();
    checks++;
    if (result !== 32'sd17) begin
      failures++; $display("FAIL mode_same_cycle got=%0d exp=17", result);
    end
  endtask

  task automatic test_random();
    int a, w;
    longint s;
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 1) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 15)) - 8;
      w = $urandom_range(0, 1) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 15)) - 8;
      s = $urandom_range(0, 1) ? longint'($signed(32'($urandom))) : longint'($urandom_range(0, 2000)) - 1000;
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, a, $urandom_range(0, 3) == 0, w,
            $urandom_range(0, 7) == 0, s, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      step();
      checks++;
      if (longint'(result) !== m_res_s || result_valid !== m_rv || ovf !== m_ovf_s) begin
        failures++;
        $display("FAIL rnd_sat cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                 i, result, result_valid, ovf, m_res_s, m_rv, m_ovf_s);
      end
      checks++;
      if (longint'(result_w) !== m_res_w || result_valid_w !== m_rv || ovf_w !== m_ovf_w) begin
        failures++;
        $display("FAIL rnd_wrap cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                 i, result_w, result_valid_w, ovf_w, m_res_w, m_rv, m_ovf_w);
      end
      checks++;
      if (a_out !== m_a_out || a_valid_out !== m_a_valid || w_out !== m_shadow ||
          w_load_out !== m_w_load || w_swap_out !== m_w_swap ||
          a_out_w !== m_a_out || a_valid_out_w !== m_a_valid || w_out_w !== m_shadow ||
          w_load_out_w !== m_w_load || w_swap_out_w !== m_w_swap) begin
        failures++;
        $display("FAIL rnd_fwd cyc=%0d got a=%0d/%0b w=%0d/%0b/%0b exp a=%0d/%0b w=%0d/%0b/%0b",
                 i, a_out, a_valid_out, w_out, w_load_out, w_swap_out,
                 m_a_out, m_a_valid, m_shadow, m_w_load, m_w_swap);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1, 5, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 6, 1, 0, 0, 0); step();
    drive(1, 1, 3, 0, 0, 0, 0, 1, 0); step();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0); step();
    checks++;
    if (result !== 32'sd30) begin
      failures++; $display("FAIL areset_pre got=%0d exp=30", result);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (result !== 32'sd0 || result_valid !== 1'b0 || a_out !== 16'sd0 || a_valid_out !== 1'b0 ||
        w_out !== 16'sd0 || w_load_out !== 1'b0 || w_swap_out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL areset_now got r=%0d/%0b a=%0d/%0b w=%0d/%0b/%0b ovf=%0b exp all 0",
               result, result_valid, a_out, a_valid_out, w_out, w_load_out, w_swap_out, ovf);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    drive(1, 1, 3, 0, 0, 1, 0, 0, 0); step();
    checks++;
    if (result !== 32'sd0 || result_valid !== 1'b1) begin
      failures++; $display("FAIL areset_cold got=%0d/%0b exp=0/1", result, result_valid);
    end
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0); step();
    checks++;
    if (result !== 32'sd0 || longint'(result) !== m_res_s) begin
      failures++; $display("FAIL areset_weights got=%0d exp=0", result);
    end
  endtask

  initial begin
    test_reset();
    test_ws_basic();
    test_double_buffer();
    test_os_accum();
    test_saturation();
    test_neg_clamp();
    test_mode_switch();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
